// File: rtl/uart_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_arb_pkg                                                         |
// | Shared state encoding, default tag base and sizing helper for the    |
// | uart_tx_arbiter block.                                               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAG  = 2'd1,
        SEND = 2'd2,
        WAIT = 2'd3
    } state_t;

    localparam logic [7:0] TAG_BASE_DEF = 8'hA0;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_arbiter_if                                                   |
// | Requester byte-stream handshake plus the uart_tx start/data/done     |
// | signals. slave = arbiter side, master = sources + transmitter side.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface uart_tx_arbiter_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]   req_valid;
    logic [8*NUM_CH-1:0] req_data;
    logic [NUM_CH-1:0]   req_last;
    logic [NUM_CH-1:0]   req_ready;
    logic                tx_start;
    logic [7:0]          tx_din;
    logic                tx_done_tick;

    modport slave (
        input  req_valid, req_data, req_last, tx_done_tick,
        output req_ready, tx_start, tx_din
    );

    modport master (
        output req_valid, req_data, req_last, tx_done_tick,
        input  req_ready, tx_start, tx_din
    );
endinterface
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rr_pick                                                         |
// | Combinational round-robin picker: first valid channel searching      |
// | upward from rr_ptr+1 with wrap.                                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = clog2_min1(NUM_CH)
) (
    input  logic [NUM_CH-1:0] valid,
    input  logic [CH_W-1:0]   rr_ptr,
    output logic [CH_W-1:0]   winner,
    output logic              any_valid
);

    always_comb begin
        int   idx;
        logic found;
        winner    = '0;
        any_valid = |valid;
        found     = 1'b0;
        idx       = 0;
        // k = NUM_CH wraps back onto rr_ptr itself, so it is searched last.
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_CH;
            if (!found && valid[idx]) begin
                winner = CH_W'(idx);
                found  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_arbiter                                                      |
// | Round-robin sharing of one uart_tx among NUM_CH byte streams, with   |
// | bursts ended by req_last, MAX_BURST beats or a valid gap.            |
// | Optional feature macro: UART_ARB_TAG_EN (sends a channel tag first). |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int         NUM_CH    = 4,
    parameter int         MAX_BURST = 16,
    parameter logic [7:0] TAG_BASE  = TAG_BASE_DEF,
    localparam int        CH_W      = clog2_min1(NUM_CH)
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_arbiter_if.slave bus,
    output logic            busy,
    output logic [CH_W-1:0] grant_id
);

    localparam int BEAT_W = $clog2(MAX_BURST + 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CH_W-1:0]     r_grant;
    logic [CH_W-1:0]     w_grant_nxt;
    logic [CH_W-1:0]     r_rr_ptr;
    logic [CH_W-1:0]     w_rr_nxt;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic [BEAT_W-1:0]   w_beat_nxt;
    logic                r_end_flag;
    logic                w_end_nxt;
    logic                r_tx_start;
    logic                w_start_nxt;
    logic [7:0]          r_tx_din;
    logic [7:0]          w_din_nxt;

    logic [CH_W-1:0]     w_winner;
    logic                w_any_valid;
    logic [NUM_CH-1:0]   w_ready;
    logic [7:0]          w_bytes [NUM_CH];
    logic                w_cur_valid;
    logic                w_cur_last;
    logic [7:0]          w_cur_byte;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign w_bytes[g] = bus.req_data[8*g +: 8];
    end

    assign w_cur_valid = bus.req_valid[r_grant];
    assign w_cur_last  = bus.req_last[r_grant];
    assign w_cur_byte  = w_bytes[r_grant];

    uart_rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_pick (
        .valid     (bus.req_valid),
        .rr_ptr    (r_rr_ptr),
        .winner    (w_winner),
        .any_valid (w_any_valid)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr_ptr;
        w_beat_nxt  = r_beat_cnt;
        w_end_nxt   = r_end_flag;
        w_start_nxt = 1'b0;
        w_din_nxt   = r_tx_din;
        case (r_state)
            IDLE: begin
                if (w_any_valid) begin
                    w_grant_nxt = w_winner;
                    w_rr_nxt    = w_winner;
                    w_beat_nxt  = '0;
`ifdef UART_ARB_TAG_EN
                    w_state_nxt = TAG;
                    w_din_nxt   = TAG_BASE | 8'(w_winner);
                    w_start_nxt = 1'b1;
`else
                    w_state_nxt = SEND;
`endif
                end
            end
            TAG: begin
`ifdef UART_ARB_TAG_EN
                if (bus.tx_done_tick) begin
                    w_state_nxt = SEND;
                end
`else
                w_state_nxt = IDLE;
`endif
            end
            SEND: begin
                if (w_cur_valid) begin
                    w_din_nxt   = w_cur_byte;
                    w_start_nxt = 1'b1;
                    w_beat_nxt  = r_beat_cnt + 1'b1;
                    w_end_nxt   = w_cur_last ||
                                  (r_beat_cnt == BEAT_W'(MAX_BURST - 1));
                    w_state_nxt = WAIT;
                end else begin
                    // A valid gap ends the burst; the channel re-arbitrates later.
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (bus.tx_done_tick) begin
                    w_state_nxt = r_end_flag ? IDLE : SEND;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= CH_W'(NUM_CH - 1);
            r_beat_cnt <= '0;
            r_end_flag <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_din   <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_end_flag <= w_end_nxt;
            r_tx_start <= w_start_nxt;
            r_tx_din   <= w_din_nxt;
        end
    end

    always_comb begin
        w_ready = '0;
        if (r_state == SEND) begin
            w_ready[r_grant] = 1'b1;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.tx_start  = r_tx_start;
    assign bus.tx_din    = r_tx_din;
    assign busy          = (r_state != IDLE);
    assign grant_id      = r_grant;

endmodule
`default_nettype wire
